// File: rtl/arm_mc_control.sv
// Multi-cycle controller for the ARM-subset core. It sequences fetch, decode,
// execute and memory phases over a shared memory port, and keeps a registered NZCV set.
module arm_mc_control #(
  parameter int unsigned COND_EN  = 1,
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic [1:0]  reg_src,
  output logic [3:0]  flags,
  output logic [3:0]  state,
  output logic        mem_timeout
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_TRAP   = 4'd10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  logic [3:0]        state_q, state_d;
  logic [3:0]        flags_q;
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_q;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cmd, cond;
  logic       is_cmp, cmd_legal, legal, cond_ok;
  logic       waiting, stall, expired;
  logic       n_f, z_f, c_f, v_f;
  logic       unused_fields;

  assign op    = instr[27:26];
  assign funct = instr[25:20];
  assign rd    = instr[15:12];
  assign cond  = instr[31:28];
  assign cmd   = funct[4:1];
  assign unused_fields = ^{instr[19:16], instr[11:0]};

  assign is_cmp    = (cmd == CMD_CMP);
  assign cmd_legal = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
                     (cmd == CMD_ORR) || is_cmp;
  assign legal     = (op == 2'b01) || (op == 2'b10) || ((op == 2'b00) && cmd_legal);

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = z_f;
      4'h1: cond_ok = !z_f;
      4'h2: cond_ok = c_f;
      4'h3: cond_ok = !c_f;
      4'h4: cond_ok = n_f;
      4'h5: cond_ok = !n_f;
      4'h6: cond_ok = v_f;
      4'h7: cond_ok = !v_f;
      4'h8: cond_ok = c_f && !z_f;
      4'h9: cond_ok = !c_f || z_f;
      4'hA: cond_ok = (n_f == v_f);
      4'hB: cond_ok = (n_f != v_f);
      4'hC: cond_ok = !z_f && (n_f == v_f);
      4'hD: cond_ok = z_f || (n_f != v_f);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
    if (COND_EN == 0) cond_ok = 1'b1;
  end

  // A ready in the same cycle the counter hits MAX_WAIT wins over the timeout.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign stall   = waiting && !mem_ready;
  assign expired = stall && (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE; else if (expired) state_d = S_TRAP;
      S_DECODE: begin
        if (!cond_ok || !legal) state_d = S_FETCH;
        else if (op == 2'b01)   state_d = S_MEMADR;
        else if (op == 2'b10)   state_d = S_BRANCH;
        else                    state_d = funct[5] ? S_EXECI : S_EXECR;
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB; else if (expired) state_d = S_TRAP;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH; else if (expired) state_d = S_TRAP;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      flags_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (waiting) wait_q <= (stall && !expired) ? wait_q + 1'b1 : '0;
      if (expired) timeout_q <= 1'b1;
      // Logical ops leave C and V alone; arithmetic ops take all four.
      if (((state_q == S_EXECR) || (state_q == S_EXECI)) && (funct[0] || is_cmp)) begin
        if ((cmd == CMD_AND) || (cmd == CMD_ORR)) flags_q[3:2] <= alu_flags[3:2];
        else                                      flags_q      <= alu_flags;
      end
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        case (cmd)
          CMD_SUB, CMD_CMP: alu_control = 3'b001;
          CMD_AND:          alu_control = 3'b010;
          CMD_ORR:          alu_control = 3'b011;
          default:          alu_control = 3'b000;
        endcase
      end
      S_ALUWB: begin
        reg_write = !is_cmp;
        pc_write  = !is_cmp && (rd == 4'hF);
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign imm_src     = op;
  assign reg_src     = {(op == 2'b01) && !funct[0], op == 2'b10};
  assign flags       = flags_q;
  assign state       = state_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_arm_mc_control.sv
// Bench for arm_mc_control: walks each instruction through its expected phase
// list (built from instruction semantics) with random memory stalls and ALU flags.
module tb_arm_mc_control;

  localparam logic [3:0] S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                         S_MEMWB = 4, S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7,
                         S_ALUWB = 8, S_BRANCH = 9, S_TRAP = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_ready;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, mem_timeout;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src, reg_src;
  logic [2:0]  alu_control;
  logic [3:0]  flags, state;

  logic        reset2, ready2;
  logic [31:0] instr2;
  logic        n_req, n_wr, n_adr, n_irw, n_pcw, n_regw, n_to;
  logic [1:0]  n_res, n_a, n_b, n_imm, n_rsrc;
  logic [2:0]  n_alu;
  logic [3:0]  n_flags, n_state;

  arm_mc_control #(.COND_EN(1), .WAIT_W(4), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_src(reg_src), .flags(flags), .state(state),
    .mem_timeout(mem_timeout));

  arm_mc_control #(.COND_EN(0), .WAIT_W(4), .MAX_WAIT(15)) dut_nocond (
    .clk(clk), .reset(reset2), .instr(instr2), .alu_flags(alu_flags), .mem_ready(ready2),
    .mem_req(n_req), .mem_write(n_wr), .adr_src(n_adr), .ir_write(n_irw),
    .pc_write(n_pcw), .reg_write(n_regw), .result_src(n_res),
    .alu_src_a(n_a), .alu_src_b(n_b), .alu_control(n_alu),
    .imm_src(n_imm), .reg_src(n_rsrc), .flags(n_flags), .state(n_state),
    .mem_timeout(n_to));

  int   checks = 0;
  int   errors = 0;
  logic [3:0] flags_m;
  logic       to_m;
  logic       force_af;
  logic [3:0] af_val;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cy;         4'h3: return !cy;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cy && !z;   4'h9: return !cy || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_dp_cmd(input logic [3:0] c);
    return c == 4'b0100 || c == 4'b0010 || c == 4'b0000 || c == 4'b1100 || c == 4'b1010;
  endfunction

  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}
  function automatic logic [5:0] exp_ctl(input logic [3:0] st, input logic [31:0] ins, input logic rdy);
    logic cmp;
    cmp = (ins[24:21] == 4'b1010);
    case (st)
      S_FETCH:  return {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0};
      S_MEMRD:  return 6'b101000;
      S_MEMWB:  return 6'b000001;
      S_MEMWR:  return 6'b111000;
      S_ALUWB:  return {4'b0000, !cmp && ins[15:12] == 4'hF, !cmp};
      S_BRANCH: return 6'b000010;
      default:  return 6'b000000;
    endcase
  endfunction

  // {result_src, alu_src_a, alu_src_b, alu_control}
  function automatic logic [8:0] exp_mux(input logic [3:0] st, input logic [31:0] ins);
    logic [2:0] op3;
    case (ins[24:21])
      4'b0010, 4'b1010: op3 = 3'b001;
      4'b0000:          op3 = 3'b010;
      4'b1100:          op3 = 3'b011;
      default:          op3 = 3'b000;
    endcase
    case (st)
      S_FETCH:  return 9'b10_01_10_000;
      S_DECODE: return 9'b00_01_10_000;
      S_MEMADR: return 9'b00_00_01_000;
      S_MEMWB:  return 9'b01_00_00_000;
      S_EXECR:  return {6'b00_00_00, op3};
      S_EXECI:  return {6'b00_00_01, op3};
      S_BRANCH: return 9'b10_10_01_000;
      default:  return 9'b0;
    endcase
  endfunction

  task automatic step(input logic rdy, input logic [3:0] st);
    mem_ready = rdy;
    alu_flags = force_af ? af_val : 4'($urandom);
    #1;
    check_val("state", 32'(state), 32'(st));
    check_val("ctl", 32'({mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}),
              32'(exp_ctl(st, instr, rdy)));
    check_val("mux", 32'({result_src, alu_src_a, alu_src_b, alu_control}), 32'(exp_mux(st, instr)));
    check_val("flags", 32'(flags), 32'(flags_m));
    check_val("timeout", 32'(mem_timeout), 32'(to_m));
    check_val("imm_reg", 32'({imm_src, reg_src}),
              32'({instr[27:26], instr[27:26] == 2'b01 && !instr[20], instr[27:26] == 2'b10}));
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) step(1'b0, st);
    step(1'b1, st);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw);
    logic [1:0] op;
    logic [3:0] cmd;
    instr = ins;
    op    = ins[27:26];
    cmd   = ins[24:21];
    wait_state(S_FETCH, fw);
    step(1'($urandom), S_DECODE);
    if (!cond_true(ins[31:28], flags_m) || op == 2'b11 || (op == 2'b00 && !is_dp_cmd(cmd)))
      return;
    if (op == 2'b01) begin
      step(1'($urandom), S_MEMADR);
      if (ins[20]) begin
        wait_state(S_MEMRD, mw);
        step(1'($urandom), S_MEMWB);
      end else begin
        wait_state(S_MEMWR, mw);
      end
    end else if (op == 2'b10) begin
      step(1'($urandom), S_BRANCH);
    end else begin
      step(1'($urandom), ins[25] ? S_EXECI : S_EXECR);
      if (ins[20] || cmd == 4'b1010) begin
        if (cmd == 4'b0000 || cmd == 4'b1100) flags_m[3:2] = alu_flags[3:2];
        else                                  flags_m      = alu_flags;
      end
      step(1'($urandom), S_ALUWB);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [3:0]  cmds [5];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    ins = $urandom;
    if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
    if (ins[27:26] == 2'b11 && $urandom_range(0, 3) != 0) ins[27:26] = 2'b00;
    if (ins[27:26] == 2'b00 && $urandom_range(0, 4) != 0) ins[24:21] = cmds[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
    return ins;
  endfunction

  initial begin
    reset = 1'b0; reset2 = 1'b0; instr = '0; instr2 = '0;
    mem_ready = 1'b0; ready2 = 1'b1; alu_flags = '0;
    force_af = 1'b0; af_val = '0; flags_m = '0; to_m = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_state", 32'(state), 32'(S_FETCH));
    check_val("rst_strobes", 32'({mem_req, mem_write, ir_write, pc_write, reg_write}), 32'h0);
    check_val("rst_flags", 32'(flags), 32'h0);
    check_val("rst_timeout", 32'(mem_timeout), 32'h0);
    reset = 1'b1;

    run_instr(32'hE0821003, 0, 0);                        // ADD R1,R2,R3
    force_af = 1'b1; af_val = 4'b0110;
    run_instr(32'hE0500000, 0, 0);                        // SUBS R0,R0,R0
    check_val("subs_flags", 32'(flags), 32'h6);
    force_af = 1'b0;
    run_instr(32'h0A000002, 0, 0);                        // BEQ taken
    run_instr(32'h1A000002, 0, 0);                        // BNE skipped
    run_instr(32'hE5921004, 0, 3);                        // LDR with 3 wait cycles
    run_instr(32'hE5821004, 1, 2);                        // STR
    force_af = 1'b1; af_val = 4'b0000;
    run_instr(32'hE0900000, 0, 0);                        // ADDS -> flags 0000
    af_val = 4'b1011;
    run_instr(32'hE0110002, 0, 0);                        // ANDS
    check_val("ands_flags", 32'(flags), 32'h8);
    force_af = 1'b0;
    run_instr(32'hE1500001, 0, 0);                        // CMP
    run_instr(32'hF0000000, 15, 0);                       // ready exactly at MAX_WAIT

    for (int k = 0; k < 300; k++)
      run_instr(rand_instr(), ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3));

    instr = 32'hF0000000;
    for (int i = 0; i < 16; i++) step(1'b0, S_FETCH);
    to_m = 1'b1;
    for (int i = 0; i < 3; i++) step(1'($urandom), S_TRAP);
    reset = 1'b0;
    #1;
    flags_m = '0; to_m = 1'b0;
    check_val("trap_rst_state", 32'(state), 32'(S_FETCH));
    check_val("trap_rst_timeout", 32'(mem_timeout), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    instr = 32'hE5921004;
    step(1'b1, S_FETCH); step(1'b1, S_DECODE); step(1'b1, S_MEMADR);
    step(1'b0, S_MEMRD); step(1'b0, S_MEMRD);
    reset = 1'b0;
    #1;
    check_val("midrst_strobes", 32'({mem_req, mem_write, ir_write, pc_write, reg_write}), 32'h0);
    check_val("midrst_state", 32'(state), 32'(S_FETCH));
    @(negedge clk);
    reset = 1'b1;
    run_instr(32'hE0821003, 2, 0);

    instr2 = 32'h00821003;
    reset2 = 1'b1;
    begin
      logic [3:0] seq [5];
      seq = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
      for (int i = 0; i < 5; i++) begin
        #1;
        check_val("nocond_state", 32'(n_state), 32'(seq[i]));
        if (seq[i] == S_ALUWB) check_val("nocond_regw", 32'(n_regw), 32'h1);
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
